// File: rtl/prog_pkg.sv
// Shared types and constants for the program loader: FSM states, error classes and
// memory sizing helpers.
package prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned MEM_BYTES      = 2 ** DEFAULT_ADDR_W;

    function automatic int unsigned mem_bytes(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream (valid/ready) into the loader and the instruction-memory write port out of it.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, we, waddr, wdata
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed program image (length, payload, checksum) into instruction memory while
// holding the CPU in reset; reports success or the error class.
module program_loader
    import prog_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    program_loader_if.slave  bus,
    output logic             cpu_hold_o,
    output logic             done_o,
    output logic             error_o,
    output logic [1:0]       error_code_o
);

    localparam int unsigned MemBytes = mem_bytes(ADDR_W);
    localparam int unsigned IdleW    = $clog2(TIMEOUT);

    loader_state_t     state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              accept;

    assign accept = bus.byte_valid && ready_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        idle_d  = idle_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d = LEN;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    sum_d   = 8'd0;
                    rem_d   = 8'd0;
                    idle_d  = '0;
                    ptr_d   = ADDR_W'(BASE_ADDR);
                end
            end
            LEN, DATA, CSUM: begin
                if (accept) begin
                    idle_d = '0;
                    sum_d  = sum_q + bus.byte_data;
                    if (state_q == LEN) begin
                        rem_d = bus.byte_data;
                        if (bus.byte_data == 8'd0 ||
                            BASE_ADDR + 32'(bus.byte_data) > MemBytes) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                            code_d  = ERR_LEN;
                        end else begin
                            state_d = DATA;
                        end
                    end else if (state_q == DATA) begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = bus.byte_data;
                        ptr_d   = ptr_q + 1'b1;
                        rem_d   = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = CSUM;
                        end
                    end else if (sum_q + bus.byte_data == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
                    // Counter reaches TIMEOUT on this edge; a same-cycle accept takes priority.
                    state_d = ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sum_q   <= 8'd0;
            rem_q   <= 8'd0;
            ptr_q   <= '0;
            idle_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign cpu_hold_o     = hold_q;
    assign done_o         = done_q;
    assign error_o        = err_q;
    assign error_code_o   = code_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: two instances (base 0 and base 250) share stimulus,
// a frame-level reference model predicts writes and final status.
module tb_program_loader;
    import prog_pkg::*;

    localparam int unsigned TO = 16;

    typedef logic [7:0] frame_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'd0;

    logic       hold0, done0, err0, hold1, done1, err1;
    logic [1:0] code0, code1;

    logic       o_ready, o_we, o_hold, o_done, o_err;
    logic [7:0] o_waddr, o_wdata;
    logic [1:0] o_code;

    int n_tests = 0;
    int n_fail  = 0;

    program_loader_if #(.ADDR_W(8)) bus0 ();
    program_loader_if #(.ADDR_W(8)) bus1 ();

    assign bus0.byte_data  = data;
    assign bus0.byte_valid = valid & ~sel;
    assign bus1.byte_data  = data;
    assign bus1.byte_valid = valid & sel;

    program_loader #(.ADDR_W(8), .BASE_ADDR(0), .TIMEOUT(TO)) dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start & ~sel),
        .bus          (bus0.slave),
        .cpu_hold_o   (hold0),
        .done_o       (done0),
        .error_o      (err0),
        .error_code_o (code0)
    );

    program_loader #(.ADDR_W(8), .BASE_ADDR(250), .TIMEOUT(TO)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start & sel),
        .bus          (bus1.slave),
        .cpu_hold_o   (hold1),
        .done_o       (done1),
        .error_o      (err1),
        .error_code_o (code1)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_ready = sel ? bus1.byte_ready : bus0.byte_ready;
        o_we    = sel ? bus1.we : bus0.we;
        o_waddr = sel ? bus1.waddr : bus0.waddr;
        o_wdata = sel ? bus1.wdata : bus0.wdata;
        o_hold  = sel ? hold1 : hold0;
        o_done  = sel ? done1 : done0;
        o_err   = sel ? err1 : err0;
        o_code  = sel ? code1 : code0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (sel=%0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(o_ready), 0);
        check_eq({tag, "_we"}, 32'(o_we), 0);
        check_eq({tag, "_waddr"}, 32'(o_waddr), 0);
        check_eq({tag, "_wdata"}, 32'(o_wdata), 0);
        check_eq({tag, "_hold"}, 32'(o_hold), 0);
        check_eq({tag, "_done"}, 32'(o_done), 0);
        check_eq({tag, "_err"}, 32'(o_err), 0);
        check_eq({tag, "_code"}, 32'(o_code), 0);
    endtask

    function automatic frame_t build(input int len, input bit corrupt);
        frame_t     fr;
        logic [7:0] s;
        logic [7:0] b;
        fr.push_back(8'(len));
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            s = s + b;
        end
        b = 8'd0 - s;
        if (corrupt) b = b + 8'(1 + $urandom % 255);
        fr.push_back(b);
        return fr;
    endfunction

    // Sends up to nsend bytes of a frame and checks every write and the final status
    // against what the frame rules predict.
    task automatic load(input frame_t fr, input int stall, input int nsend, input bit mid_start);
        int  len;
        int  base;
        int  total;
        int  n;
        int  sum;
        bit  bad_len;
        len     = int'(fr[0]);
        base    = sel ? 250 : 0;
        bad_len = (len == 0) || (base + len > 256);
        total   = bad_len ? 1 : len + 2;
        n       = (nsend < total) ? nsend : total;
        sum     = 0;
        for (int i = 0; i < total; i++) sum += int'(fr[i]);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_hold", 32'(o_hold), 1);
        check_eq("start_ready", 32'(o_ready), 1);
        check_eq("start_err_clr", 32'(o_err), 0);
        check_eq("start_done_clr", 32'(o_done), 0);
        check_eq("start_code_clr", 32'(o_code), 0);

        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stall; s++) begin
                tick();
                check_eq("we_idle", 32'(o_we), 0);
            end
            if (mid_start && i == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check_eq("mid_start_we", 32'(o_we), 0);
                check_eq("mid_start_ready", 32'(o_ready), 1);
                check_eq("mid_start_hold", 32'(o_hold), 1);
            end
            data  = fr[i];
            valid = 1'b1;
            check_eq("ready_pre_accept", 32'(o_ready), 1);
            tick();
            valid = 1'b0;
            if (!bad_len && i >= 1 && i <= len) begin
                check_eq("we", 32'(o_we), 1);
                check_eq("waddr", 32'(o_waddr), 32'(base + i - 1));
                check_eq("wdata", 32'(o_wdata), 32'(fr[i]));
            end else begin
                check_eq("we_none", 32'(o_we), 0);
            end
        end

        if (bad_len) begin
            check_eq("len_err", 32'(o_err), 1);
            check_eq("len_code", 32'(o_code), 32'(ERR_LEN));
            check_eq("len_hold", 32'(o_hold), 1);
            check_eq("len_done", 32'(o_done), 0);
        end else if (n < total) begin
            for (int c = 0; c < int'(TO) - 1; c++) tick();
            check_eq("to_early", 32'(o_err), 0);
            tick();
            check_eq("to_err", 32'(o_err), 1);
            check_eq("to_code", 32'(o_code), 32'(ERR_TIMEOUT));
            check_eq("to_hold", 32'(o_hold), 1);
        end else if (sum % 256 == 0) begin
            check_eq("ok_done", 32'(o_done), 1);
            check_eq("ok_hold", 32'(o_hold), 0);
            check_eq("ok_err", 32'(o_err), 0);
            check_eq("ok_code", 32'(o_code), 32'(ERR_NONE));
        end else begin
            check_eq("cs_err", 32'(o_err), 1);
            check_eq("cs_code", 32'(o_code), 32'(ERR_CSUM));
            check_eq("cs_hold", 32'(o_hold), 1);
            check_eq("cs_done", 32'(o_done), 0);
        end
        check_eq("end_ready", 32'(o_ready), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fr;
        int     len;

        tick();
        tick();
        rst = 1'b0;
        sel = 1'b0;
        check_reset_vals("reset0");
        sel = 1'b1;
        check_reset_vals("reset1");

        sel = 1'b0;
        fr = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
        load(fr, 0, 99, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("done_holds", 32'(o_done), 1);
        check_eq("done_hold_cpu", 32'(o_hold), 0);

        fr = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        load(fr, 0, 99, 1'b0);

        fr = '{8'h00, 8'h00};
        load(fr, 0, 99, 1'b0);

        sel = 1'b1;
        load(build(7, 1'b0), 0, 99, 1'b0);
        load(build(6, 1'b0), 0, 99, 1'b0);

        sel = 1'b0;
        load(build(4, 1'b0), 5, 99, 1'b0);
        load(build(3, 1'b0), 0, 2, 1'b0);
        load(build(4, 1'b0), 0, 99, 1'b1);

        // Reset lands on the edge that accepts the second payload byte.
        fr = build(5, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data  = fr[i];
            valid = 1'b1;
            tick();
        end
        data = fr[2];
        rst  = 1'b1;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        check_reset_vals("rst_mid");
        tick();
        check_eq("rst_no_we", 32'(o_we), 0);
        check_eq("rst_idle_ready", 32'(o_ready), 0);

        load(build(2, 1'b1), 0, 99, 1'b0);
        load(build(2, 1'b0), 1, 99, 1'b0);

        for (int k = 0; k < 20; k++) begin
            sel = 1'($urandom % 2);
            len = 1 + int'($urandom % 10);
            load(build(len, ($urandom % 4) == 0), int'($urandom % 3), 99, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
